// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

    // Default FIFO word width; must match the FIFO's rdata width.
    localparam int unsigned DATA_W_DEF = 16;

    // Largest supported words-per-beat; sizes fill counters and keep masks.
    localparam int unsigned PACK_MAX = 8;

    // Wide enough to hold 0..PACK_MAX.
    typedef logic [3:0] fill_t;

    typedef enum logic [1:0] {
        StCollect,
        StHold,
        StDrain
    } pack_state_e;

    // Lane-valid mask with the low 'fill' bits set; callers slice to PACK bits.
    function automatic logic [PACK_MAX-1:0] keep_mask(input fill_t fill);
        logic [PACK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < PACK_MAX; i++) begin
            if (fill_t'(i) < fill) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_out.sv
// Output register slot of the read-side packer: loads a packed beat and
// holds it stable until the downstream accepts it.
module fifo_rd_packer_out
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PACK   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [DATA_W*PACK-1:0]   load_data,
    input  logic [PACK-1:0]          load_keep,
    input  logic                     m_ready,
    output logic [DATA_W*PACK-1:0]   m_data,
    output logic [PACK-1:0]          m_keep,
    output logic                     m_valid,
    output logic                     slot_free
);

    logic [DATA_W*PACK-1:0] data_q;
    logic [PACK-1:0]        keep_q;
    logic                   valid_q;

    // Slot can take a new beat if empty or the current one leaves this edge.
    assign slot_free = !valid_q || m_ready;

    // Beat register: load has priority, otherwise drop valid on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            keep_q  <= load_keep;
            valid_q <= 1'b1;
        end else if (m_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_valid = valid_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: pops DATA_W-bit words and packs PACK of them
// into one valid/ready beat, with explicit flush of a partial beat.
// Optional build macro FIFO_RD_PACKER_SEQCHK_EN enables the incrementing
// word sequence checker driving seq_err; otherwise seq_err is tied low.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PACK   = 2
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic                     rempty,
    input  logic [DATA_W-1:0]        rdata,
    input  logic                     rvalid,
    output logic                     rinc,
    input  logic                     flush,
    output logic [DATA_W*PACK-1:0]   m_data,
    output logic [PACK-1:0]          m_keep,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     seq_err
);

    localparam fill_t FillFull = fill_t'(PACK);
    localparam fill_t FillLast = fill_t'(PACK - 1);

    pack_state_e            state_q, state_d;
    fill_t                  fill_q, fill_d;
    logic                   rinc_q;
    logic                   flush_pend_q, flush_pend_d;
    logic [DATA_W-1:0]      lane_q [PACK];
    logic [DATA_W-1:0]      lane_d [PACK];
    logic                   accept;
    logic                   slot_free;
    logic                   load;
    logic [DATA_W*PACK-1:0] load_data;
    logic [PACK-1:0]        load_keep;
    logic [PACK_MAX-1:0]    mask;
    logic [4:0]             inflight;

    // Only words we actually asked for are taken.
    assign accept = rvalid && rinc_q;

    // Words held plus the one in flight; a new pop is allowed only if it
    // can never land in a full buffer.
    assign inflight = {1'b0, fill_q} + {4'b0, rinc_q};
    assign rinc = !rrst && !rempty && !flush_pend_q &&
                  ((inflight < 5'(PACK)) || (inflight == 5'(PACK) && slot_free));

    // Assembly, beat completion, drain and flush bookkeeping.
    always_comb begin
        lane_d       = lane_q;
        fill_d       = fill_q;
        flush_pend_d = flush_pend_q;
        load         = 1'b0;
        load_keep    = '0;
        load_data    = '0;
        mask         = keep_mask(fill_q);
        for (int i = 0; i < PACK; i++) begin
            if (accept && fill_q == fill_t'(i)) lane_d[i] = rdata;
        end
        case (state_q)
            StHold: begin
                // No word can arrive here: rinc was blocked while full.
                if (slot_free) begin
                    load      = 1'b1;
                    load_keep = '1;
                    fill_d    = '0;
                end
            end
            default: begin
                if (accept) begin
                    if (fill_q == FillLast) begin
                        if (slot_free) begin
                            load      = 1'b1;
                            load_keep = '1;
                            fill_d    = '0;
                        end else begin
                            fill_d = FillFull;
                        end
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end else if (state_q == StDrain && !rinc_q && slot_free) begin
                    load         = 1'b1;
                    load_keep    = mask[PACK-1:0];
                    fill_d       = '0;
                    flush_pend_d = 1'b0;
                end
            end
        endcase
        if (flush_pend_q && fill_q == '0 && !rinc_q) flush_pend_d = 1'b0;
        if (flush) flush_pend_d = 1'b1;
        // Unused lanes of a partial beat go out as zero.
        for (int i = 0; i < PACK; i++) begin
            load_data[i*DATA_W +: DATA_W] = load_keep[i] ? lane_d[i] : '0;
        end
        if (fill_d == FillFull) begin
            state_d = StHold;
        end else if (flush_pend_d && fill_d != '0) begin
            state_d = StDrain;
        end else begin
            state_d = StCollect;
        end
    end

    // State, fill level, read tracking and assembly lanes.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q      <= StCollect;
            fill_q       <= '0;
            rinc_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            for (int i = 0; i < PACK; i++) lane_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            rinc_q       <= rinc;
            flush_pend_q <= flush_pend_d;
            for (int i = 0; i < PACK; i++) lane_q[i] <= lane_d[i];
        end
    end

    fifo_rd_packer_out #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_out (
        .clk       (rclk),
        .rst       (rrst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_valid   (m_valid),
        .slot_free (slot_free)
    );

`ifdef FIFO_RD_PACKER_SEQCHK_EN
    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] prev_inc;
    logic              have_prev_q;
    logic              seq_err_q;

    assign prev_inc = prev_q + 1'b1;

    // Sticky check that accepted words increment by one; first word exempt.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else if (accept) begin
            prev_q      <= rdata;
            have_prev_q <= 1'b1;
            if (have_prev_q && rdata != prev_inc) seq_err_q <= 1'b1;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer (PACK=2) with a FIFO model and a
// beat scoreboard.
module tb_fifo_rd_packer;

    localparam int unsigned DW = 16;
    localparam int unsigned PK = 2;
    localparam int unsigned BW = DW * PK;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          rempty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rvalid = 1'b0;
    logic          rinc;
    logic          flush = 1'b0;
    logic [BW-1:0] m_data;
    logic [PK-1:0] m_keep;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          seq_err;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] exp_data_q[$];
    logic [PK-1:0] exp_keep_q[$];
    logic [DW-1:0] part[$];
    logic [DW-1:0] next_word = '0;
    int            pops = 0;
    int            beats = 0;
    logic [PK-1:0] last_keep = '0;

    logic          s_rinc = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready = 1'b0;
    logic [BW-1:0] s_data = '0;
    logic [PK-1:0] s_keep = '0;

    fifo_rd_packer #(
        .DATA_W (DW),
        .PACK   (PK)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rempty  (rempty),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rinc    (rinc),
        .flush   (flush),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .seq_err (seq_err)
    );

    always #5 rclk = ~rclk;

    // Sample everything the next rising edge will act on.
    always @(negedge rclk) begin
        s_rinc  = rinc;
        s_valid = m_valid;
        s_ready = m_ready;
        s_data  = m_data;
        s_keep  = m_keep;
    end

    // FIFO model (one-cycle read latency) and output scoreboard.
    always @(posedge rclk) begin : fifo_and_sb
        logic [BW-1:0] b;
        logic [BW-1:0] ed;
        logic [PK-1:0] ek;
        #1;
        if (s_rinc) begin
            rdata  = next_word;
            rvalid = 1'b1;
            part.push_back(next_word);
            next_word = next_word + 16'd1;
            pops++;
            if (part.size() == PK) begin
                b = '0;
                for (int i = 0; i < PK; i++) b[i*DW +: DW] = part[i];
                exp_data_q.push_back(b);
                exp_keep_q.push_back('1);
                part.delete();
            end
        end else begin
            rvalid = 1'b0;
        end
        if (s_valid && s_ready) begin
            beats++;
            last_keep = s_keep;
            checks++;
            if (exp_data_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data=%h keep=%b, required no beat",
                         s_data, s_keep);
            end else begin
                ed = exp_data_q.pop_front();
                ek = exp_keep_q.pop_front();
                if (s_data !== ed || s_keep !== ek) begin
                    errors++;
                    $display("FAIL beat_compare: got data=%h keep=%b, required data=%h keep=%b",
                             s_data, s_keep, ed, ek);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rclk);
            #2;
        end
    endtask

    // One-cycle flush pulse; the model emits whatever partial words it holds.
    task automatic pulse_flush();
        logic [BW-1:0] b;
        logic [PK-1:0] k;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        if (part.size() > 0) begin
            b = '0;
            k = '0;
            for (int i = 0; i < part.size(); i++) begin
                b[i*DW +: DW] = part[i];
                k[i] = 1'b1;
            end
            exp_data_q.push_back(b);
            exp_keep_q.push_back(k);
            part.delete();
        end
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        tick(2);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL reset_m_valid: got %b, required 0", m_valid);
        end
        checks++;
        if (m_data !== '0) begin
            errors++; $display("FAIL reset_m_data: got %h, required 0", m_data);
        end
        checks++;
        if (m_keep !== '0) begin
            errors++; $display("FAIL reset_m_keep: got %b, required 0", m_keep);
        end
        checks++;
        if (seq_err !== 1'b0) begin
            errors++; $display("FAIL reset_seq_err: got %b, required 0", seq_err);
        end
        rempty = 1'b0;
        #1;
        checks++;
        if (rinc !== 1'b0) begin
            errors++; $display("FAIL reset_rinc: got %b, required 0", rinc);
        end
        rempty = 1'b1;
        tick(1);
        rrst = 1'b0;
        tick(2);
    endtask

    task automatic test_stream();
        int cnt;
        int lows;
        int b0;
        m_ready = 1'b1;
        rempty  = 1'b0;
        cnt = 0;
        @(negedge rclk);
        checks++;
        if (rinc !== 1'b1) begin
            errors++; $display("FAIL stream_first_rinc: got %b, required 1", rinc);
        end
        while (!m_valid && cnt < 20) begin
            cnt++;
            @(negedge rclk);
        end
        checks++;
        if (cnt != 3) begin
            errors++; $display("FAIL stream_latency: got %0d cycles, required 3", cnt);
        end
        checks++;
        if (m_data !== 32'h0001_0000 || m_keep !== 2'b11) begin
            errors++;
            $display("FAIL stream_first_beat: got %h/%b, required 00010000/11", m_data, m_keep);
        end
        repeat (4) @(negedge rclk);
        lows = 0;
        b0 = beats;
        repeat (20) begin
            @(negedge rclk);
            if (rinc !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++; $display("FAIL stream_rinc_gap: got %0d low cycles, required 0", lows);
        end
        checks++;
        if (beats - b0 != 10) begin
            errors++; $display("FAIL stream_throughput: got %0d beats, required 10", beats - b0);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] held;
        int moved;
        tick(1);
        m_ready = 1'b0;
        repeat (5) @(negedge rclk);
        held = m_data;
        moved = 0;
        repeat (5) begin
            @(negedge rclk);
            if (m_data !== held || m_valid !== 1'b1) moved++;
        end
        checks++;
        if (moved != 0) begin
            errors++; $display("FAIL bp_stable: got %0d changes, required 0", moved);
        end
        checks++;
        if (rinc !== 1'b0) begin
            errors++; $display("FAIL bp_rinc_low: got %b, required 0", rinc);
        end
        checks++;
        if (pops - beats * PK != 2 * PK) begin
            errors++;
            $display("FAIL bp_words_held: got %0d, required %0d", pops - beats * PK, 2 * PK);
        end
        tick(1);
        m_ready = 1'b1;
        #1;
        checks++;
        if (rinc !== 1'b1) begin
            errors++; $display("FAIL bp_rinc_resume: got %b, required 1", rinc);
        end
        tick(8);
    endtask

    task automatic test_flush();
        int b0;
        rempty = 1'b1;
        tick(4);
        if (part.size() == 0) begin
            rempty = 1'b0;
            tick(1);
            rempty = 1'b1;
            tick(3);
        end
        pulse_flush();
        tick(6);
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++; $display("FAIL flush_drained: got %0d pending, required 0", exp_data_q.size());
        end
        checks++;
        if (last_keep !== 2'b01) begin
            errors++; $display("FAIL flush_keep: got %b, required 01", last_keep);
        end
        b0 = beats;
        pulse_flush();
        tick(6);
        checks++;
        if (beats != b0) begin
            errors++; $display("FAIL flush_empty: got %0d beats, required 0", beats - b0);
        end
        rempty = 1'b0;
        #1;
        checks++;
        if (rinc !== 1'b1) begin
            errors++; $display("FAIL flush_release: got rinc=%b, required 1", rinc);
        end
        tick(6);
    endtask

    task automatic test_flush_hold();
        int b0;
        m_ready = 1'b0;
        tick(10);
        checks++;
        if (rinc !== 1'b0) begin
            errors++; $display("FAIL fhold_rinc_low: got %b, required 0", rinc);
        end
        rempty = 1'b1;
        pulse_flush();
        tick(2);
        b0 = beats;
        m_ready = 1'b1;
        tick(8);
        checks++;
        if (beats - b0 != 2) begin
            errors++; $display("FAIL fhold_beats: got %0d, required 2", beats - b0);
        end
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++; $display("FAIL fhold_drained: got %0d pending, required 0", exp_data_q.size());
        end
        rempty = 1'b0;
        #1;
        checks++;
        if (rinc !== 1'b1) begin
            errors++; $display("FAIL fhold_release: got rinc=%b, required 1", rinc);
        end
        tick(5);
    endtask

    task automatic test_seq();
        logic exp_err;
`ifdef FIFO_RD_PACKER_SEQCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rempty = 1'b1;
        tick(4);
        next_word = next_word + 16'd2;
        rempty = 1'b0;
        tick(1);
        rempty = 1'b1;
        @(negedge rclk);
        checks++;
        if (seq_err !== 1'b0) begin
            errors++; $display("FAIL seq_early: got %b, required 0", seq_err);
        end
        @(negedge rclk);
        checks++;
        if (seq_err !== exp_err) begin
            errors++; $display("FAIL seq_set: got %b, required %b", seq_err, exp_err);
        end
        tick(1);
        pulse_flush();
        tick(6);
        checks++;
        if (seq_err !== exp_err) begin
            errors++; $display("FAIL seq_sticky: got %b, required %b", seq_err, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] first;
        int cnt;
        m_ready = 1'b0;
        rempty  = 1'b0;
        tick(10);
        rrst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== '0 || rinc !== 1'b0 ||
            seq_err !== 1'b0) begin
            errors++;
            $display("FAIL rmid_outputs: got v=%b d=%h k=%b rinc=%b err=%b, required all 0",
                     m_valid, m_data, m_keep, rinc, seq_err);
        end
        exp_data_q.delete();
        exp_keep_q.delete();
        part.delete();
        tick(2);
        first = {next_word + 16'd1, next_word};
        rrst = 1'b0;
        m_ready = 1'b1;
        cnt = 0;
        @(negedge rclk);
        while (!m_valid && cnt < 20) begin
            cnt++;
            @(negedge rclk);
        end
        checks++;
        if (!m_valid || m_data !== first) begin
            errors++;
            $display("FAIL rmid_first_beat: got v=%b d=%h, required v=1 d=%h", m_valid, m_data,
                     first);
        end
        tick(6);
        rempty = 1'b1;
        tick(4);
        pulse_flush();
        tick(6);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_hold();
        test_seq();
        test_reset_mid();
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++; $display("FAIL final_drained: got %0d pending, required 0", exp_data_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, in the read clock domain. Pops 16-bit words through the FIFO's rinc/rempty/rdata/rvalid interface and packs PACK consecutive words into one wide beat on a valid/ready output stream. Supports explicit flush of a partial beat and keeps full throughput under continuous downstream ready.

## Interface
- DATA_W, 16, FIFO word width; must match the FIFO's rdata width.
- PACK, 2, words per output beat; legal range 2..8.
- rclk  input  1  read-domain clock; all logic on its rising edge.
- rrst  input  1  asynchronous, active-high reset.
- rempty  input  1  FIFO empty flag, synchronous to rclk.
- rdata  input  DATA_W  FIFO read data, meaningful when rvalid=1.
- rvalid  input  1  FIFO read-data valid; one cycle after an accepted rinc.
- rinc  output  1  FIFO pop request; combinational.
- flush  input  1  request to emit the partial beat; single-cycle pulse.
- m_data  output  DATA_W*PACK  packed beat; first-read word in bits [DATA_W-1:0].
- m_keep  output  PACK  lane-valid mask; bit i covers word lane i.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the beat when m_valid=1.
- seq_err  output  1  sticky sequence-error flag (see Configuration).

## Operation
- Word accept: a word is captured only when rvalid=1 and rinc_q=1. rinc_q is the registered rinc. An rvalid without rinc_q is ignored.
- Assembly buffer: holds fill = 0..PACK words. The word is written to lane fill, then fill increments.
- Completion: a beat completes when a word lands in lane PACK-1.
  - If the output slot is free (m_valid=0 or m_ready=1) on that edge, the beat moves straight into the output register with m_keep all ones, and fill returns to 0.
  - Otherwise fill becomes PACK, which is the HOLD state.
- Output slot: m_data/m_keep/m_valid are registered and stay stable while m_valid=1 and m_ready=0.
- rinc = !rrst && !rempty && !flush_pend && (fill + rinc_q < PACK || (fill + rinc_q == PACK && (!m_valid || m_ready))).
  - This guarantees fill never exceeds PACK and no rvalid arrives into a full buffer.
- State machine:
  - COLLECT: fill < PACK.
  - HOLD: fill == PACK and the output slot is blocked. Moves to COLLECT on the first edge where the slot frees; the held beat is transferred.
  - DRAIN: flush_pend=1 and fill > 0. When rinc_q=0 and the slot is free, transfers the partial beat with m_keep[i]=1 for i<fill, unused lanes zero, fill←0, then returns to COLLECT.
- flush sets flush_pend. flush_pend clears on the partial-beat transfer, or on the next edge if fill==0 and rinc_q==0.
- flush arriving while in HOLD: the full beat goes out first, then the flush is honoured on the remaining fill.

## Timing
- Reset (async assert, rising-edge deassert) sets these values:
  - m_valid=0, m_data=0, m_keep=0, seq_err=0, rinc=0.
  - Internally, fill=0, rinc_q=0, flush_pend=0.
- Reset mid-operation discards the assembly contents, the held beat and in-flight reads.
- Latency: first rinc at cycle 0 → word at cycle 1 → with PACK=2, m_valid at cycle 3.
- Throughput: with rempty=0 and m_ready=1 continuously, rinc stays high every cycle and there is one beat per PACK cycles.
- Backpressure: with m_ready held low, at most PACK (output) + PACK (assembly) words are read before rinc drops. rinc rises again in the cycle m_ready returns high.
- The rinc→m_ready combinational path is intentional and is constrained as a same-domain path.

## Configuration
- FIFO_RD_PACKER_SEQCHK_EN defined:
  - Each accepted word is compared with previous accepted word + 1, modulo 2^DATA_W. The first word after reset is exempt.
  - A mismatch sets seq_err one cycle after the offending rvalid. seq_err holds until rrst.
- Not defined: seq_err is tied to 0 and the comparator and previous-word register are absent.

## Structure
- Shared package fifo_pkg holds:
  - the DATA_W default constant;
  - the packer state enum (COLLECT, HOLD, DRAIN);
  - a keep_mask(fill) function returning the PACK-bit mask.
- One sub-module, fifo_rd_packer_out: the output register slot (load, hold, m_valid/m_ready handshake). The top holds the assembly buffer, the FSM, rinc generation and the sequence check.

## Test plan
- Continuous stream: FIFO fed 0,1,2,… with m_ready=1, PACK=2.
  - Expect beats 0x0001_0000, 0x0003_0002, … with m_keep=2'b11.
  - One beat every 2 cycles; first m_valid 3 cycles after the first rinc.
- Backpressure: m_ready=0 for 10 cycles mid-stream.
  - Exactly 4 words are popped, then rinc=0 and m_data stays stable.
  - After m_ready=1, beats resume with no lost or duplicated word.
- Flush: 3 words (0,1,2), then rempty=1 and a flush pulse.
  - Expect 0x0001_0000 with keep 2'b11, then 0x0000_0002 with keep 2'b01.
  - A flush with fill=0 produces no beat.
- Flush during HOLD: full beat out first, then the partial beat with the correct keep.
- Sequence check (macro defined): words 0,1,2,5.
  - seq_err=1 one cycle after word 5 is accepted and stays 1; clears only on rrst.
  - Macro undefined: seq_err stays 0.
- Reset mid-operation: assert rrst while in HOLD with rinc_q=1.
  - All outputs go to 0 immediately.
  - After release, the first beat contains only words read after reset.
